change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000: cycles allowed from eject assertion to coin_done edge before declaring a jam.
REQ-002 SHALL have parameter GAP, default 4: idle cycles enforced between consecutive ejections.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port change1, input, 1 bit: one-cycle pulse requesting one 1-unit coin.
REQ-006 SHALL have port change2, input, 1 bit: one-cycle pulse requesting one 2-unit coin.
REQ-007 SHALL have port change22, input, 1 bit: one-cycle pulse requesting two 2-unit coins.
REQ-008 SHALL have port coin_done, input, 1 bit: asynchronous level from the hopper sensor; it rises once per coin dropped.
REQ-009 SHALL have port eject1, output, 1 bit: high while the hopper is commanded to drop a 1-unit coin.
REQ-010 SHALL have port eject2, output, 1 bit: high while the hopper is commanded to drop a 2-unit coin.
REQ-011 SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE or either pending count is nonzero.
REQ-012 SHALL have port jam, output, 1 bit: sticky fault flag.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag set when a request is lost.

Function
REQ-014 SHALL pass coin_done through a 2-flop synchronizer; a "done edge" is sync stage 2 high while its previous-cycle value was low.
REQ-015 SHALL keep 3-bit counters pend1 and pend2, range 0..7.
REQ-016 SHALL apply request increments in the cycle the pulse is sampled: change1 adds 1 to pend1, change2 adds 1 to pend2, change22 adds 2 to pend2; change2 and change22 together add 3.
REQ-017 SHALL saturate each counter at 7; any unapplied increment units SHALL be dropped and SHALL set overflow.
REQ-018 SHALL apply a same-cycle increment and done-edge decrement to the same counter together as the net result; saturation SHALL be checked after the net result.
REQ-019 SHALL use FSM states IDLE, EJ1, EJ2, GAP, FAULT.
REQ-020 SHALL transition from IDLE to EJ2 when pend2>0, else to EJ1 when pend1>0; 2-unit coins take priority.
REQ-021 SHALL drive eject1 and eject2 as registered outputs: eject2=1 exactly while in EJ2, eject1=1 exactly while in EJ1; the two are never high together.
REQ-022 SHALL, on a done edge in EJ1 or EJ2, decrement the matching counter, go to GAP, and drop the eject line the next cycle.
REQ-023 SHALL stay in GAP for exactly GAP cycles, then return to IDLE; done edges outside EJ1 and EJ2 SHALL be ignored.
REQ-024 SHALL run a timeout counter cleared on entry to EJ1 or EJ2; if it reaches TIMEOUT with no done edge, the FSM SHALL enter FAULT.
REQ-025 SHALL, in FAULT, hold jam=1 and eject1=eject2=0 until reset; requests SHALL still accumulate in pend1/pend2 with saturation.
REQ-026 SHALL allow latency from a request pulse in IDLE with empty counters to eject high of exactly 2 cycles: the counter updates on edge 1 and the FSM enters EJx on edge 2.

Reset
REQ-027 SHALL, on reset low, asynchronously force state=IDLE, pend1=pend2=0, synchronizer flops=0, timeout and gap counters=0, and eject1=eject2=busy=jam=overflow=0.
REQ-028 SHALL treat reset asserted mid-ejection as abandoning that coin without a decrement.
REQ-029 SHALL resume normal operation on the first clock edge after reset deasserts.

Verification
REQ-030 SHALL test: change22 pulse, with coin_done pulsed about 10 cycles after each eject2 rise -> two eject2 windows separated by at least GAP low cycles, pend2 2->1->0, busy falls after the second GAP, eject1 never high.
REQ-031 SHALL test: change1 and change2 in the same cycle -> eject2 serviced first, then eject1; final pend1=pend2=0.
REQ-032 SHALL test: 9 change2 pulses with no coin_done -> pend2 saturates at 7 and overflow=1 after the 8th pulse.
REQ-033 SHALL test: TIMEOUT=20, change1, coin_done held low -> eject1 high for 20 cycles, then FAULT with jam=1, eject1=0, pend1=1; a later change1 gives pend1=2 and no eject.
REQ-034 SHALL test: a done edge in the same cycle as a change2 pulse while in EJ2 with pend2=3 -> pend2 remains 3.
REQ-035 SHALL test: reset low for 1 cycle while eject2=1 -> all outputs 0 immediately (asynchronous), counters 0, no ejection after release.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Request/eject bundle between the vending controller and the coin dispenser.
interface change_dispenser_if;
  logic change1;
  logic change2;
  logic change22;
  logic coin_done;
  logic eject1;
  logic eject2;
  logic busy;
  logic jam;
  logic overflow;

  // Controller side: issues change requests and relays the hopper sensor
  modport master (
    output change1, change2, change22, coin_done,
    input  eject1, eject2, busy, jam, overflow
  );

  // Dispenser side
  modport slave (
    input  change1, change2, change22, coin_done,
    output eject1, eject2, busy, jam, overflow
  );
endinterface

// File: rtl/change_dispenser.sv
// Coin change dispenser: queues 1-unit and 2-unit coin requests in saturating
// counters and drives a hopper one coin at a time, 2-unit coins first, with an
// enforced idle gap between drops and a jam timeout per drop.
module change_dispenser #(
  parameter int unsigned TIMEOUT = 1000,  // must be >= 1
  parameter int unsigned GAP     = 4      // must be >= 1
) (
  input logic             clk,
  input logic             reset,
  change_dispenser_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_EJ1   = 3'd1;
  localparam logic [2:0] ST_EJ2   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  logic          sync1_q, sync2_q, sync3_q;
  logic          done_edge;
  logic [2:0]    pend1_q, pend1_d;
  logic [2:0]    pend2_q, pend2_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          eject1_q, eject2_q, jam_q;
  logic          dec1, dec2;
  logic [3:0]    sum1, sum2;
  logic          lost1, lost2;

  // sync3_q is the previous-cycle value of the second synchronizer stage
  assign done_edge = sync2_q & ~sync3_q;

  // Synchronize the asynchronous hopper sensor and keep one cycle of history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= bus.coin_done;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Net increment/decrement per counter, then saturate; lost units flag overflow
  always_comb begin
    dec1  = done_edge && (state_q == ST_EJ1);
    dec2  = done_edge && (state_q == ST_EJ2);
    // A decrement only happens in EJx, where the matching counter is nonzero
    sum1  = {1'b0, pend1_q} + {3'b000, bus.change1} - {3'b000, dec1};
    sum2  = {1'b0, pend2_q} + {3'b000, bus.change2} + {2'b00, bus.change22, 1'b0}
            - {3'b000, dec2};
    lost1 = (sum1 > 4'd7);
    lost2 = (sum2 > 4'd7);
    pend1_d = lost1 ? 3'd7 : sum1[2:0];
    pend2_d = lost2 ? 3'd7 : sum2[2:0];
    ovf_d   = ovf_q | lost1 | lost2;
  end

  // Ejection sequencing: pick a coin, wait for its drop or time out, then idle GAP cycles
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        gap_d = '0;
        if (pend2_q != 3'd0) begin
          state_d = ST_EJ2;
        end else if (pend1_q != 3'd0) begin
          state_d = ST_EJ1;
        end
      end
      ST_EJ1, ST_EJ2: begin
        if (done_edge) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset abandons any coin in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pend1_q  <= 3'd0;
      pend2_q  <= 3'd0;
      ovf_q    <= 1'b0;
      tmo_q    <= '0;
      gap_q    <= '0;
      eject1_q <= 1'b0;
      eject2_q <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      // Decoded from next state so each eject line tracks its EJx state exactly
      eject1_q <= (state_d == ST_EJ1);
      eject2_q <= (state_d == ST_EJ2);
      jam_q    <= (state_d == ST_FAULT);
    end
  end

  assign bus.eject1   = eject1_q;
  assign bus.eject2   = eject2_q;
  assign bus.jam      = jam_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != ST_IDLE) || (pend1_q != 3'd0) || (pend2_q != 3'd0);

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized request
// bursts served by a hopper model, checked against coin-count bookkeeping.
module tb_change_dispenser;

  localparam int unsigned TMO  = 20;
  localparam int unsigned GAPC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  change_dispenser_if dif ();

  change_dispenser #(
    .TIMEOUT(TMO),
    .GAP    (GAPC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  int checks = 0;
  int passes = 0;

  // Request plan indexed by hopper-loop cycle
  bit req1[0:127];
  bit req2[0:127];
  bit req22[0:127];

  // Hopper-run observations
  int h_n1, h_n2, h_first, h_first_rise, h_min_gap, h_busy_delay;
  bit h_both, h_timeout;
  int pend2_at_rise[$];

  task automatic clear_plan();
    for (int i = 0; i < 128; i++) begin
      req1[i] = 1'b0; req2[i] = 1'b0; req22[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    dif.change1 = 1'b0; dif.change2 = 1'b0; dif.change22 = 1'b0; dif.coin_done = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle request pulse; returns at the negedge after it was sampled
  task automatic pulse(input bit c1, input bit c2, input bit c22);
    @(negedge clk);
    dif.change1 = c1; dif.change2 = c2; dif.change22 = c22;
    @(negedge clk);
    dif.change1 = 1'b0; dif.change2 = 1'b0; dif.change22 = 1'b0;
  endtask

  // Hopper model: raises coin_done 'delay' cycles after each eject rise and holds
  // it 3 cycles; replays the request plan; runs until the dispenser goes quiet.
  task automatic run_hopper(input int delay, input int min_cycles, input int budget);
    int cyc, countdown, hold, low_cnt, fall_cyc;
    bit p1, p2, pb, e1, e2, seen_fall;
    h_n1 = 0; h_n2 = 0; h_first = 0; h_first_rise = -1; h_min_gap = 1000;
    h_busy_delay = -1; h_both = 1'b0; h_timeout = 1'b0;
    pend2_at_rise.delete();
    countdown = 0; hold = 0; low_cnt = 0; fall_cyc = -1; seen_fall = 1'b0;
    p1 = dif.eject1; p2 = dif.eject2; pb = dif.busy;
    cyc = 1;
    while (1) begin
      e1 = dif.eject1;
      e2 = dif.eject2;
      if (e1 && e2) h_both = 1'b1;
      if ((e1 && !p1) || (e2 && !p2)) begin
        if (seen_fall && low_cnt < h_min_gap) h_min_gap = low_cnt;
        if (h_first_rise < 0) h_first_rise = cyc;
        countdown = delay;
      end
      if (e2 && !p2) begin
        h_n2++;
        pend2_at_rise.push_back(int'(dut.pend2_q));
        if (h_first == 0) h_first = 2;
      end
      if (e1 && !p1) begin
        h_n1++;
        if (h_first == 0) h_first = 1;
      end
      if ((!e1 && p1) || (!e2 && p2)) begin
        seen_fall = 1'b1;
        fall_cyc  = cyc;
      end
      if (!e1 && !e2) low_cnt++; else low_cnt = 0;
      if (pb && !dif.busy && fall_cyc >= 0) h_busy_delay = cyc - fall_cyc;
      if (cyc >= min_cycles && !dif.busy && !e1 && !e2 && countdown == 0 && hold == 0) break;
      if (cyc >= budget) begin
        h_timeout = 1'b1;
        break;
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) dif.coin_done = 1'b0;
      end
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          dif.coin_done = 1'b1;
          hold = 3;
        end
      end
      dif.change1  = (cyc < 128) ? req1[cyc]  : 1'b0;
      dif.change2  = (cyc < 128) ? req2[cyc]  : 1'b0;
      dif.change22 = (cyc < 128) ? req22[cyc] : 1'b0;
      p1 = e1; p2 = e2; pb = dif.busy;
      @(negedge clk);
      cyc++;
    end
    dif.change1 = 1'b0; dif.change2 = 1'b0; dif.change22 = 1'b0; dif.coin_done = 1'b0;
  endtask

  task automatic test_reset();
    dif.change1 = 1'b0; dif.change2 = 1'b0; dif.change22 = 1'b0; dif.coin_done = 1'b0;
    reset = 1'b0;
    #12;
    checks++;
    if ({dif.eject1, dif.eject2, dif.busy, dif.jam, dif.overflow} !== 5'b0)
      $display("FAIL reset_outputs: got %b expected 00000",
               {dif.eject1, dif.eject2, dif.busy, dif.jam, dif.overflow});
    else passes++;
    checks++;
    if ({dut.pend1_q, dut.pend2_q} !== 6'd0)
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", dut.pend1_q, dut.pend2_q);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_change22();
    do_reset();
    clear_plan();
    pulse(1'b0, 1'b0, 1'b1);
    run_hopper(10, 2, 500);
    checks++;
    if (h_timeout !== 1'b0) $display("FAIL c22_quiesce: got timeout expected idle");
    else passes++;
    checks++;
    if (h_first_rise !== 2) $display("FAIL c22_latency: got %0d expected 2", h_first_rise);
    else passes++;
    checks++;
    if (h_n2 !== 2) $display("FAIL c22_windows: got %0d expected 2", h_n2);
    else passes++;
    checks++;
    if (h_n1 !== 0) $display("FAIL c22_no_eject1: got %0d expected 0", h_n1);
    else passes++;
    checks++;
    if (pend2_at_rise.size() != 2 || pend2_at_rise[0] !== 2 || pend2_at_rise[1] !== 1)
      $display("FAIL c22_pend_seq: got %p expected '{2, 1}", pend2_at_rise);
    else passes++;
    checks++;
    if (h_min_gap < GAPC) $display("FAIL c22_gap: got %0d expected >=%0d", h_min_gap, GAPC);
    else passes++;
    checks++;
    if (h_busy_delay !== GAPC)
      $display("FAIL c22_busy_fall: got %0d expected %0d", h_busy_delay, GAPC);
    else passes++;
    checks++;
    if (dut.pend2_q !== 3'd0) $display("FAIL c22_pend_end: got %0d expected 0", dut.pend2_q);
    else passes++;
  endtask

  task automatic test_priority();
    do_reset();
    clear_plan();
    pulse(1'b1, 1'b1, 1'b0);
    run_hopper(5, 2, 500);
    checks++;
    if (h_first !== 2) $display("FAIL prio_first: got eject%0d expected eject2", h_first);
    else passes++;
    checks++;
    if (h_n1 !== 1 || h_n2 !== 1)
      $display("FAIL prio_counts: got %0d/%0d expected 1/1", h_n1, h_n2);
    else passes++;
    checks++;
    if (h_both !== 1'b0) $display("FAIL prio_exclusive: got both high expected never");
    else passes++;
    checks++;
    if ({dut.pend1_q, dut.pend2_q} !== 6'd0)
      $display("FAIL prio_pend_end: got %0d/%0d expected 0/0", dut.pend1_q, dut.pend2_q);
    else passes++;
  endtask

  task automatic test_saturation();
    int exp_p;
    bit exp_o;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      pulse(1'b0, 1'b1, 1'b0);
      exp_p = (k > 7) ? 7 : k;
      exp_o = (k > 7);
      checks++;
      if (int'(dut.pend2_q) !== exp_p || dif.overflow !== exp_o)
        $display("FAIL sat_pulse%0d: got pend2=%0d ovf=%b expected pend2=%0d ovf=%b",
                 k, dut.pend2_q, dif.overflow, exp_p, exp_o);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    int  hi;
    bit  seen, any_ej;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    hi = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dif.eject1) begin
        hi++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    checks++;
    if (hi !== int'(TMO)) $display("FAIL tmo_width: got %0d expected %0d", hi, TMO);
    else passes++;
    checks++;
    if (dif.jam !== 1'b1 || dif.eject1 !== 1'b0 || dut.pend1_q !== 3'd1)
      $display("FAIL tmo_fault: got jam=%b ej1=%b pend1=%0d expected 1/0/1",
               dif.jam, dif.eject1, dut.pend1_q);
    else passes++;
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (dut.pend1_q !== 3'd2) $display("FAIL tmo_accum: got %0d expected 2", dut.pend1_q);
    else passes++;
    any_ej = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dif.eject1 || dif.eject2) any_ej = 1'b1;
    end
    checks++;
    if (any_ej !== 1'b0 || dif.jam !== 1'b1)
      $display("FAIL tmo_stuck: got eject=%b jam=%b expected 0/1", any_ej, dif.jam);
    else passes++;
  endtask

  task automatic test_net_update();
    do_reset();
    pulse(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (dif.eject2 !== 1'b1 || dut.pend2_q !== 3'd3)
      $display("FAIL net_setup: got ej2=%b pend2=%0d expected 1/3", dif.eject2, dut.pend2_q);
    else passes++;
    dif.coin_done = 1'b1;
    repeat (2) @(negedge clk);
    dif.change2 = 1'b1;  // sampled on the same edge that applies the done-edge decrement
    @(negedge clk);
    dif.change2 = 1'b0;
    checks++;
    if (dut.pend2_q !== 3'd3) $display("FAIL net_pend2: got %0d expected 3", dut.pend2_q);
    else passes++;
    checks++;
    if (dif.eject2 !== 1'b0) $display("FAIL net_eject_drop: got %b expected 0", dif.eject2);
    else passes++;
    dif.coin_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit any_ej;
    do_reset();
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (dif.eject2 !== 1'b1) $display("FAIL rstmid_setup: got %b expected 1", dif.eject2);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if ({dif.eject1, dif.eject2, dif.busy, dif.jam, dif.overflow} !== 5'b0)
      $display("FAIL rstmid_async: got %b expected 00000",
               {dif.eject1, dif.eject2, dif.busy, dif.jam, dif.overflow});
    else passes++;
    checks++;
    if ({dut.pend1_q, dut.pend2_q} !== 6'd0)
      $display("FAIL rstmid_counters: got %0d/%0d expected 0/0", dut.pend1_q, dut.pend2_q);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    any_ej = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dif.eject1 || dif.eject2) any_ej = 1'b1;
    end
    checks++;
    if (any_ej !== 1'b0 || dif.busy !== 1'b0)
      $display("FAIL rstmid_after: got eject=%b busy=%b expected 0/0", any_ej, dif.busy);
    else passes++;
  endtask

  // Totals stay within counter capacity, so every requested coin must be dropped
  task automatic test_random();
    int t1, t2, r, dly;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      clear_plan();
      t1 = 0; t2 = 0;
      for (int c = 1; c <= 60; c++) begin
        if ($urandom_range(0, 5) == 0 && t1 < 7) begin
          req1[c] = 1'b1;
          t1++;
        end
        r = $urandom_range(0, 9);
        if (r == 0 && t2 <= 6) begin
          req2[c] = 1'b1; t2 += 1;
        end else if (r == 1 && t2 <= 5) begin
          req22[c] = 1'b1; t2 += 2;
        end else if (r == 2 && t2 <= 4) begin
          req2[c] = 1'b1; req22[c] = 1'b1; t2 += 3;
        end
      end
      dly = $urandom_range(3, 12);
      run_hopper(dly, 64, 3000);
      checks++;
      if (h_timeout !== 1'b0) $display("FAIL rnd%0d_quiesce: got timeout expected idle", round);
      else passes++;
      checks++;
      if (h_n1 !== t1 || h_n2 !== t2)
        $display("FAIL rnd%0d_coins: got %0d/%0d expected %0d/%0d", round, h_n1, h_n2, t1, t2);
      else passes++;
      checks++;
      if (h_both !== 1'b0 || h_min_gap < GAPC)
        $display("FAIL rnd%0d_spacing: got both=%b gap=%0d expected 0/>=%0d",
                 round, h_both, h_min_gap, GAPC);
      else passes++;
      checks++;
      if (dif.overflow !== 1'b0 || dif.jam !== 1'b0 || {dut.pend1_q, dut.pend2_q} !== 6'd0)
        $display("FAIL rnd%0d_end: got ovf=%b jam=%b pend=%0d/%0d expected 0/0/0/0",
                 round, dif.overflow, dif.jam, dut.pend1_q, dut.pend2_q);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_change22();
    test_priority();
    test_saturation();
    test_timeout();
    test_net_update();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
